gol_generation_sequencer: RTL
=============================

// Module: gol_generation_sequencer
// PURPOSE
// Hardware host for the Game-of-Life engine: sequences the engine's start/completed control handshake
// for N back-to-back generations, ping-ponging source/result buffers in on-chip memory port s2.
// Optionally seeds buffer A with an LFSR pattern first; owns the s2 port while seeding, else passes engine through.
// Sits between the HPS command PIOs and the engine wrapper; the HPS issues one command and waits for done.
// PARAMETERS
// ADDR_W 12 : s2 address width; DATA_W 8 : s2 data width (one cell per word)
// BOARD_CELLS 1024 : cells per buffer; BUF_A_BASE 0, BUF_B_BASE 1024 : buffer base addresses
// GEN_W 16 : generation counter width; ENG_RESET_CYCLES 4 : engine reset pulse length
// TIMEOUT_CYCLES 1048576 : max cycles waiting for eng_completed per generation
// PORTS
// fpga_clk_50 in 1 clock; hps_fpga_reset_n in 1 reset, asynchronous, active-low
// cmd_go in 1 start command (sampled high in IDLE); cmd_seed in 1 seed buffer A first
// cmd_generations in GEN_W generation count; cmd_seed_value in 16 LFSR seed
// busy out 1; done out 1; timeout out 1; gen_count out GEN_W; final_address out ADDR_W
// eng_reset out 1; eng_start out 1; eng_initialize out 1; eng_completed in 1
// eng_starting_address out ADDR_W; eng_result_address out ADDR_W
// eng_mem_address in ADDR_W; eng_mem_write in 1; eng_mem_writedata in DATA_W (engine master side)
// mem_address out ADDR_W; mem_write out 1; mem_writedata out DATA_W (to s2; readdata wired direct to engine)
// BEHAVIOUR
// Reset: state IDLE, busy=0, done=0, timeout=0, gen_count=0, final_address=BUF_A_BASE, eng_reset=1,
//   eng_start=0, eng_initialize=0, src=BUF_A_BASE, dst=BUF_B_BASE. Reset mid-run aborts immediately.
// States: IDLE, ENG_RST, SEED, START, WAIT_DONE, RELEASE, FINISH, FAULT.
// IDLE: eng_reset held 1. cmd_go=1 -> latch N=cmd_generations, cmd_seed, seed; clear done/timeout/gen_count;
//   src=A, dst=B; busy=1 next cycle; -> ENG_RST. cmd_go while busy=1 ignored.
// ENG_RST: eng_reset=1 for ENG_RESET_CYCLES cycles, then eng_reset=0 -> SEED if seeding, else START;
//   if N==0 -> FINISH directly (final_address=BUF_A_BASE, gen_count=0).
// SEED: one write/cycle, addr BUF_A_BASE+i, i=0..BOARD_CELLS-1, data={(DATA_W-1)'b0, lfsr[0]}; LFSR steps
//   each write. Fibonacci 16-bit, taps 16,14,13,11; seed 0 replaced by 16'hACE1. Then -> START (or FINISH if N==0).
// START: eng_starting_address=src, eng_result_address=dst (stable until RELEASE exits); eng_start=1;
//   eng_initialize=1 only when gen_count==0; -> WAIT_DONE.
// WAIT_DONE: hold eng_start; eng_completed=1 -> RELEASE. Timer > TIMEOUT_CYCLES -> FAULT.
// RELEASE: eng_start=0, eng_initialize=0; wait eng_completed=0 (same timeout); then gen_count+1, swap src/dst;
//   if gen_count+1==N -> FINISH else START. eng_completed already low on entry: exit after one cycle.
// FINISH: final_address=last dst; busy=0, done=1 held until next accepted cmd_go; -> IDLE.
// FAULT: timeout=1 (held until next cmd_go), eng_start=0, eng_reset=1, busy=0, done=0; -> IDLE.
// Port mux (combinational): SEED -> sequencer drives mem_*; START/WAIT_DONE/RELEASE -> mem_* = eng_mem_*;
//   all other states: mem_address=eng_mem_address, mem_write=0, mem_writedata=eng_mem_writedata.
// Arithmetic: gen_count wraps never (N<=2^GEN_W-1); addresses BASE+i truncated to ADDR_W.
// Latency: cmd_go to eng_start = ENG_RESET_CYCLES+1 cycles (no seed), +BOARD_CELLS with seed.
// STRUCTURE
// gol_seq_defs.vh: state encodings, LFSR taps/default seed, default buffer bases.
// Sub-module gol_seed_lfsr: 16-bit LFSR with load/step, zero-seed substitution. FSM, counters, mux in top.
// TESTING
// N=3, no seed, engine model completes 10 cycles after start -> 3 handshakes, src/dst A/B,B/A,A/B;
//   eng_initialize only on 1st; done=1, final_address=1024, gen_count=3.
// cmd_seed=1, seed 0 -> 1024 writes addr 0..1023 using seed 16'hACE1 pattern; no engine writes reach s2 meanwhile.
// N=0 -> no eng_start ever; done=1, final_address=0 after ENG_RESET_CYCLES+1.
// Engine never completes -> timeout=1 after TIMEOUT_CYCLES, eng_reset=1, busy=0; next cmd_go clears timeout.
// cmd_go pulsed during WAIT_DONE -> ignored; hps_fpga_reset_n low mid-WAIT_DONE -> all outputs reset values.

Source files
------------

// File: rtl/gol_generation_sequencer_pkg.sv
// Shared definitions for the Game-of-Life generation sequencer.
// State encoding, LFSR polynomial, default seed and buffer bases.
package gol_generation_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENG_RST,
        S_SEED,
        S_START,
        S_WAIT_DONE,
        S_RELEASE,
        S_FINISH,
        S_FAULT
    } seq_state_t;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
    localparam int DEF_BUF_A_BASE = 0;
    localparam int DEF_BUF_B_BASE = 1024;

    // Fibonacci x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/gol_seed_lfsr.sv
// 16-bit seeding LFSR with load/step; a zero seed is replaced by
// the default seed. Ports: clock, reset, load, step, seed, bit_out.
module gol_seed_lfsr
    import gol_generation_sequencer_pkg::*;
(
    input  logic        fpga_clk_50,
    input  logic        hps_fpga_reset_n,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic        bit_out
);

    logic [15:0] lfsr_q;

    always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
        if (!hps_fpga_reset_n) begin
            lfsr_q <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            lfsr_q <= (seed == 16'h0) ? LFSR_DEFAULT_SEED : seed;
        end else if (step) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign bit_out = lfsr_q[0];

endmodule

// File: rtl/gol_generation_sequencer.sv
// Sequences N engine generations over ping-pong buffers, optional LFSR seed.
// Ports: cmd_* from HPS, status out, eng_* handshake, s2 mem_* mux.
module gol_generation_sequencer #(
    parameter int ADDR_W           = 12,
    parameter int DATA_W           = 8,
    parameter int BOARD_CELLS      = 1024,
    parameter int BUF_A_BASE       = 0,
    parameter int BUF_B_BASE       = 1024,
    parameter int GEN_W            = 16,
    parameter int ENG_RESET_CYCLES = 4,
    parameter int TIMEOUT_CYCLES   = 1048576
) (
    input  logic              fpga_clk_50,
    input  logic              hps_fpga_reset_n,
    input  logic              cmd_go,
    input  logic              cmd_seed,
    input  logic [GEN_W-1:0]  cmd_generations,
    input  logic [15:0]       cmd_seed_value,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [GEN_W-1:0]  gen_count,
    output logic [ADDR_W-1:0] final_address,
    output logic              eng_reset,
    output logic              eng_start,
    output logic              eng_initialize,
    input  logic              eng_completed,
    output logic [ADDR_W-1:0] eng_starting_address,
    output logic [ADDR_W-1:0] eng_result_address,
    input  logic [ADDR_W-1:0] eng_mem_address,
    input  logic              eng_mem_write,
    input  logic [DATA_W-1:0] eng_mem_writedata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata
);
    import gol_generation_sequencer_pkg::*;

    localparam logic [ADDR_W-1:0] A_ADDR = ADDR_W'(BUF_A_BASE);
    localparam logic [ADDR_W-1:0] B_ADDR = ADDR_W'(BUF_B_BASE);
    localparam logic [31:0] RST_LAST  = 32'(ENG_RESET_CYCLES - 1);
    localparam logic [31:0] SEED_LAST = 32'(BOARD_CELLS - 1);
    localparam logic [31:0] TO_LIM    = 32'(TIMEOUT_CYCLES);

    seq_state_t        state, state_nxt;
    logic [31:0]       cnt;
    logic [GEN_W-1:0]  n_gen;
    logic              seed_en;
    logic [ADDR_W-1:0] src, dst;
    logic              lfsr_bit;
    logic              go_ok;
    logic              last_gen;

    assign go_ok    = (state == S_IDLE) && cmd_go;
    assign last_gen = (gen_count + GEN_W'(1)) == n_gen;

    gol_seed_lfsr u_lfsr (
        .fpga_clk_50      (fpga_clk_50),
        .hps_fpga_reset_n (hps_fpga_reset_n),
        .load             (go_ok),
        .step             (state == S_SEED),
        .seed             (cmd_seed_value),
        .bit_out          (lfsr_bit)
    );

    always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
        if (!hps_fpga_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (cmd_go) state_nxt = S_ENG_RST;
            end
            S_ENG_RST: begin
                if (cnt == RST_LAST) begin
                    if (seed_en)              state_nxt = S_SEED;
                    else if (n_gen == '0)     state_nxt = S_FINISH;
                    else                      state_nxt = S_START;
                end
            end
            S_SEED: begin
                if (cnt == SEED_LAST)
                    state_nxt = (n_gen == '0) ? S_FINISH : S_START;
            end
            S_START: state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (eng_completed)      state_nxt = S_RELEASE;
                else if (cnt >= TO_LIM) state_nxt = S_FAULT;
            end
            S_RELEASE: begin
                if (!eng_completed)
                    state_nxt = last_gen ? S_FINISH : S_START;
                else if (cnt >= TO_LIM)
                    state_nxt = S_FAULT;
            end
            S_FINISH: state_nxt = S_IDLE;
            S_FAULT:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // cnt measures time spent in the current state; any transition clears it.
    always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
        if (!hps_fpga_reset_n) begin
            cnt           <= '0;
            n_gen         <= '0;
            seed_en       <= 1'b0;
            src           <= A_ADDR;
            dst           <= B_ADDR;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            gen_count     <= '0;
            final_address <= A_ADDR;
        end else begin
            cnt <= (state_nxt != state) ? '0 : cnt + 32'd1;
            if (go_ok) begin
                n_gen     <= cmd_generations;
                seed_en   <= cmd_seed;
                src       <= A_ADDR;
                dst       <= B_ADDR;
                busy      <= 1'b1;
                done      <= 1'b0;
                timeout   <= 1'b0;
                gen_count <= '0;
            end
            if (state == S_RELEASE && !eng_completed) begin
                gen_count <= gen_count + GEN_W'(1);
                src       <= dst;
                dst       <= src;
            end
            // After the final swap, src holds the last result buffer.
            if (state == S_FINISH) begin
                final_address <= src;
                busy          <= 1'b0;
                done          <= 1'b1;
            end
            if (state == S_FAULT) begin
                timeout <= 1'b1;
                busy    <= 1'b0;
                done    <= 1'b0;
            end
        end
    end

    always_comb begin
        eng_reset            = 1'b0;
        eng_start            = 1'b0;
        eng_initialize       = 1'b0;
        eng_starting_address = src;
        eng_result_address   = dst;
        mem_address          = eng_mem_address;
        mem_write            = 1'b0;
        mem_writedata        = eng_mem_writedata;
        unique case (state)
            S_SEED: begin
                mem_address   = A_ADDR + cnt[ADDR_W-1:0];
                mem_write     = 1'b1;
                mem_writedata = {{(DATA_W-1){1'b0}}, lfsr_bit};
            end
            S_START, S_WAIT_DONE: begin
                eng_start      = 1'b1;
                eng_initialize = (gen_count == '0);
                mem_write      = eng_mem_write;
            end
            S_RELEASE: begin
                mem_write = eng_mem_write;
            end
            S_IDLE, S_ENG_RST, S_FINISH, S_FAULT: begin
                eng_reset = 1'b1;
            end
            default: eng_reset = 1'b1;
        endcase
    end

endmodule
